// File: rtl/regfile_scoreboard_if.sv
// Bundle of decode/writeback signals for the register file with scoreboard.
// The master side is the pipeline (or bench); the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]     rs_addr;
    logic [NRD*XLEN-1:0]   rs_dout;
    logic [NRD-1:0]        rs_busy;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  is_ecall;
    logic                  is_halted;
    logic [NREGS*XLEN-1:0] print_reg;

    modport master (
        output rs_addr, issue_en, issue_rd, wr_en, wr_addr, wr_data, is_ecall,
        input  rs_dout, rs_busy, is_halted, print_reg
    );

    modport slave (
        input  rs_addr, issue_en, issue_rd, wr_en, wr_addr, wr_data, is_ecall,
        output rs_dout, rs_busy, is_halted, print_reg
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD bypassed read ports, one write port,
// a pending-write scoreboard and sticky ECALL halt detection.
module regfile_scoreboard #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NREGS     = 32,
    parameter int unsigned     NRD       = 2,
    parameter int unsigned     SP_IDX    = 2,
    parameter logic [XLEN-1:0] SP_INIT   = 'h2ffc,
    parameter int unsigned     HALT_IDX  = 17,
    parameter int unsigned     HALT_CODE = 10
) (
    input logic                  clk,
    input logic                  reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int unsigned     AW       = $clog2(NREGS);
    localparam logic [AW-1:0]   HaltAddr = AW'(HALT_IDX);
    localparam logic [XLEN-1:0] HaltVal  = XLEN'(HALT_CODE);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             wr_ok;
    logic [XLEN-1:0]  halt_chk;
    logic [AW-1:0]    rd_addr;

    assign wr_ok = bus.wr_en && !halted_q;

    // Register file array; x0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                rf_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_ok && bus.wr_addr != '0) begin
            rf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Issue beats a same-cycle write: the issuing instruction is the new producer.
    always_comb begin
        busy_d = busy_q;
        if (!halted_q) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (bus.issue_en && bus.issue_rd == AW'(r)) begin
                    busy_d[r] = 1'b1;
                end else if (bus.wr_en && bus.wr_addr == AW'(r)) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        if (HaltAddr == '0) begin
            halt_chk = '0;
        end else if (wr_ok && bus.wr_addr == HaltAddr) begin
            halt_chk = bus.wr_data;
        end else begin
            halt_chk = rf_q[HaltAddr];
        end
        halted_d = halted_q | (bus.is_ecall && halt_chk == HaltVal);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // A write landing this cycle is forwarded, so it is neither stale data nor a hazard.
    always_comb begin
        bus.rs_dout = '0;
        bus.rs_busy = '0;
        rd_addr     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_addr = bus.rs_addr[k*AW +: AW];
            if (rd_addr == '0) begin
                bus.rs_dout[k*XLEN +: XLEN] = '0;
            end else if (wr_ok && bus.wr_addr == rd_addr) begin
                bus.rs_dout[k*XLEN +: XLEN] = bus.wr_data;
            end else begin
                bus.rs_dout[k*XLEN +: XLEN] = rf_q[rd_addr];
            end
            bus.rs_busy[k] = busy_q[rd_addr] && !(bus.wr_en && bus.wr_addr == rd_addr);
        end
    end

    always_comb begin
        bus.print_reg = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            bus.print_reg[r*XLEN +: XLEN] = rf_q[r];
        end
    end

    assign bus.is_halted = halted_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file: reset, bypass, scoreboard, halt, and a
// wide 64-entry / 3-port / 64-bit instance.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
    regfile_scoreboard_if #(.XLEN(64), .NREGS(64), .NRD(3)) bus_b ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(64), .NRD(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic idle_a();
        bus_a.rs_addr  = '0;
        bus_a.issue_en = 1'b0;
        bus_a.issue_rd = '0;
        bus_a.wr_en    = 1'b0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        bus_a.is_ecall = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.rs_addr  = '0;
        bus_b.issue_en = 1'b0;
        bus_b.issue_rd = '0;
        bus_b.wr_en    = 1'b0;
        bus_b.wr_addr  = '0;
        bus_b.wr_data  = '0;
        bus_b.is_ecall = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        // Create some non-reset state first.
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h1234_5678;
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd8;
        @(negedge clk);
        idle_a();
        bus_a.rs_addr = {5'd8, 5'd4};
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b10) begin
            errors++; $display("FAIL pre_reset_busy: got %b want %b", bus_a.rs_busy, 2'b10);
        end
        #1 reset = 1'b1;
        #1;
        for (int r = 0; r < 32; r++) begin
            exp = (r == 2) ? 32'h2ffc : 32'h0;
            checks++;
            if (bus_a.print_reg[r*32 +: 32] !== exp) begin
                errors++;
                $display("FAIL reset_print_reg[%0d]: got %h want %h", r, bus_a.print_reg[r*32 +: 32], exp);
            end
        end
        checks++;
        if (bus_a.rs_busy !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b want 00", bus_a.rs_busy);
        end
        checks++;
        if (bus_a.is_halted !== 1'b0) begin
            errors++; $display("FAIL reset_halted: got %b want 0", bus_a.is_halted);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'hDEAD_BEEF;
        bus_a.rs_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus_a.rs_dout[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_read: got %h want deadbeef", bus_a.rs_dout[31:0]);
        end
        checks++;
        if (bus_a.print_reg[5*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL array_before_edge: got %h want 0", bus_a.print_reg[5*32 +: 32]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_a.print_reg[5*32 +: 32] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL array_after_edge: got %h want deadbeef", bus_a.print_reg[5*32 +: 32]);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'hFFFF_FFFF;
        bus_a.rs_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus_a.rs_dout[63:32] !== 32'h0) begin
            errors++; $display("FAIL x0_bypass: got %h want 0", bus_a.rs_dout[63:32]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_a.print_reg[31:0] !== 32'h0 || bus_a.rs_dout[63:32] !== 32'h0) begin
            errors++; $display("FAIL x0_write: got %h want 0", bus_a.print_reg[31:0]);
        end
        @(negedge clk);
        idle_a();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd7;
        bus_a.rs_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b00) begin
            errors++; $display("FAIL busy_before_issue_edge: got %b want 00", bus_a.rs_busy);
        end
        @(negedge clk);
        bus_a.issue_en = 1'b0;
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b11) begin
            errors++; $display("FAIL busy_after_issue: got %b want 11", bus_a.rs_busy);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h77;
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd7;
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b00) begin
            errors++; $display("FAIL busy_masked_by_write: got %b want 00", bus_a.rs_busy);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b0; bus_a.issue_en = 1'b0;
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b11) begin
            errors++; $display("FAIL issue_wins_over_write: got %b want 11", bus_a.rs_busy);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h0000_0777;
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b00 || bus_a.rs_dout !== 64'h0000_0777_0000_0777) begin
            errors++;
            $display("FAIL write_clears_busy: got busy %b data %h want 00 / 0000077700000777",
                     bus_a.rs_busy, bus_a.rs_dout);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b00) begin
            errors++; $display("FAIL busy_stays_clear: got %b want 00", bus_a.rs_busy);
        end
        idle_a();
    endtask

    task automatic test_halt();
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd17; bus_a.wr_data = 32'd9;
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd12;
        @(negedge clk);
        idle_a();
        bus_a.is_ecall = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_a.is_halted !== 1'b0) begin
            errors++; $display("FAIL no_halt_on_9: got %b want 0", bus_a.is_halted);
        end
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd17; bus_a.wr_data = 32'd10;
        bus_a.is_ecall = 1'b1;
        #1;
        checks++;
        if (bus_a.is_halted !== 1'b0) begin
            errors++; $display("FAIL halt_before_edge: got %b want 0", bus_a.is_halted);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_a.is_halted !== 1'b1) begin
            errors++; $display("FAIL halt_via_bypass: got %b want 1", bus_a.is_halted);
        end
        @(negedge clk);
        idle_a();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'd1;
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd9;
        bus_a.rs_addr = {5'd9, 5'd3};
        #1;
        checks++;
        if (bus_a.rs_dout[31:0] !== 32'h0) begin
            errors++; $display("FAIL no_bypass_when_halted: got %h want 0", bus_a.rs_dout[31:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_a.print_reg[3*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL write_frozen: got %h want 0", bus_a.print_reg[3*32 +: 32]);
        end
        checks++;
        if (bus_a.print_reg[17*32 +: 32] !== 32'd10) begin
            errors++; $display("FAIL halt_reg_value: got %h want a", bus_a.print_reg[17*32 +: 32]);
        end
        @(negedge clk);
        idle_a();
        bus_a.rs_addr = {5'd9, 5'd12};
        #1;
        checks++;
        if (bus_a.rs_busy !== 2'b01 || bus_a.is_halted !== 1'b1) begin
            errors++;
            $display("FAIL frozen_scoreboard: got busy %b halted %b want 01 / 1",
                     bus_a.rs_busy, bus_a.is_halted);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'd5;
        bus_a.issue_en = 1'b1; bus_a.issue_rd = 5'd13;
        bus_a.is_ecall = 1'b1;
        bus_a.rs_addr = {5'd13, 5'd12};
        reset = 1'b1;
        #1;
        checks++;
        if (bus_a.is_halted !== 1'b0 || bus_a.rs_busy !== 2'b00) begin
            errors++;
            $display("FAIL midstream_reset_state: got halted %b busy %b want 0 / 00",
                     bus_a.is_halted, bus_a.rs_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_a.print_reg[17*32 +: 32] !== 32'h0 || bus_a.print_reg[5*32 +: 32] !== 32'h0
            || bus_a.print_reg[2*32 +: 32] !== 32'h2ffc) begin
            errors++;
            $display("FAIL midstream_reset_array: got x17 %h x5 %h x2 %h want 0 / 0 / 2ffc",
                     bus_a.print_reg[17*32 +: 32], bus_a.print_reg[5*32 +: 32],
                     bus_a.print_reg[2*32 +: 32]);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_a();
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd6; bus_a.wr_data = 32'h66;
        @(posedge clk); #1;
        checks++;
        if (bus_a.print_reg[6*32 +: 32] !== 32'h66) begin
            errors++; $display("FAIL first_edge_after_reset: got %h want 66", bus_a.print_reg[6*32 +: 32]);
        end
        @(negedge clk);
        idle_a();
    endtask

    task automatic test_wide();
        checks++;
        if (bus_b.print_reg[2*64 +: 64] !== 64'h2ffc || bus_b.print_reg[63*64 +: 64] !== 64'h0) begin
            errors++;
            $display("FAIL wide_reset: got x2 %h x63 %h want 2ffc / 0",
                     bus_b.print_reg[2*64 +: 64], bus_b.print_reg[63*64 +: 64]);
        end
        @(negedge clk);
        bus_b.rs_addr = {6'd63, 6'd63, 6'd63};
        bus_b.issue_en = 1'b1; bus_b.issue_rd = 6'd63;
        @(negedge clk);
        bus_b.issue_en = 1'b0;
        #1;
        checks++;
        if (bus_b.rs_busy !== 3'b111) begin
            errors++; $display("FAIL wide_busy: got %b want 111", bus_b.rs_busy);
        end
        @(negedge clk);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 6'd63; bus_b.wr_data = 64'hCAFE_BABE_1234_5678;
        #1;
        checks++;
        if (bus_b.rs_dout !== {3{64'hCAFE_BABE_1234_5678}} || bus_b.rs_busy !== 3'b000) begin
            errors++;
            $display("FAIL wide_bypass: got %h busy %b want cafebabe12345678 x3 / 000",
                     bus_b.rs_dout, bus_b.rs_busy);
        end
        @(negedge clk);
        bus_b.wr_en = 1'b0;
        #1;
        checks++;
        if (bus_b.print_reg[63*64 +: 64] !== 64'hCAFE_BABE_1234_5678 || bus_b.rs_busy !== 3'b000
            || bus_b.rs_dout !== {3{64'hCAFE_BABE_1234_5678}}) begin
            errors++;
            $display("FAIL wide_after_write: got x63 %h busy %b want cafebabe12345678 / 000",
                     bus_b.print_reg[63*64 +: 64], bus_b.rs_busy);
        end
        idle_b();
    endtask

    initial begin
        reset = 1'b1;
        idle_a();
        idle_b();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_halt();
        test_reset_midstream();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
